fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Instruction-fetch controller for the pipelined MIPS core.
- Owns the program counter driven into the combinational instruction memory (word index = PC >> 2), and registers the returned word into the IF/ID latch.
- Sequences fetch under decode stalls, branch/jump redirects and the halt opcode.
- Sits between the hazard/branch logic (EX/ID) and the instruction memory.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
HALT_OPCODE, 6'b111111, opcode field (instr[31:26]) that stops fetch
MEM_WORDS, 65, number of instruction-memory words; word index >= MEM_WORDS is out of range

Ports:
clk  input  1  system clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall_i  input  1  decode stall: hold PC and IF/ID contents
redirect_valid  input  1  taken branch/jump this cycle
redirect_pc  input  32  target address for redirect
instr_i  input  32  instruction word returned combinationally for pc_o
pc_o  output  32  fetch address to instruction memory
if_id_valid  output  1  IF/ID latch holds a real instruction
if_id_instr  output  32  latched instruction (32'h0 when invalid)
if_id_pc  output  32  address of latched instruction
halted  output  1  high while in HALT state

Behaviour:
- One clock domain (clk); reset is synchronous and active-high. Reset has priority over all other inputs.
- Reset values: pc_o=RESET_PC, if_id_valid=0, if_id_instr=0, if_id_pc=0, halted=0, state=RUN.
- States:
  - RUN: fetching.
  - HALT: fetch stopped; halted=1; pc_o frozen.
- Per-cycle priority: reset > redirect_valid > stall_i > normal fetch.
- Redirect (either state):
  - pc_o <= {redirect_pc[31:2],2'b00}; misaligned targets are silently aligned.
  - if_id_valid<=0, if_id_instr<=0, if_id_pc<=0 (one-bubble flush).
  - State -> RUN and halted<=0. A halt fetched down a wrong path is cancelled.
  - Redirect wins over a simultaneous stall_i.
- RUN, stall_i=1, no redirect: pc_o and all IF/ID outputs hold.
- RUN, normal fetch:
  - If (pc_o>>2) >= MEM_WORDS: do not latch; if_id_valid<=0, if_id_instr<=0; state -> HALT; pc_o holds.
  - Else if instr_i[31:26]==HALT_OPCODE: latch it (if_id_valid<=1, if_id_instr<=instr_i, if_id_pc<=pc_o); state -> HALT; pc_o holds (not incremented).
  - Else: latch it the same way; pc_o <= pc_o+4. Addition is modulo 2^32; 32'hFFFF_FFFC wraps to 0.
- HALT:
  - stall_i=1: IF/ID holds, so a latched halt instruction is not lost.
  - Otherwise: if_id_valid<=0 and if_id_instr<=0 on the first non-stalled cycle, and stay invalid after that.
  - pc_o never changes except on redirect or reset.
- Latency:
  - pc_o to IF/ID is 1 cycle.
  - A redirect costs exactly 1 bubble cycle; the target instruction appears in IF/ID 2 edges after redirect_valid is sampled.
- Reset during a stall or in HALT returns to the reset values on the next edge, regardless of other inputs.

Optional Feature:
- Macro: FETCH_PERF_EN.
- When defined, adds three outputs:
  - fetch_count (32): increments on every cycle an instruction is latched valid.
  - bubble_count (32): increments on every redirect-flush cycle and every stalled cycle in RUN.
  - redirect_count (16): increments on each redirect_valid while not in reset.
- All three clear on reset and saturate at all-ones (no wrap).
- When undefined, these ports and registers do not exist; the remaining behaviour is identical.

Test Plan:
- Reset then 3 free-running cycles with memory words 0x00411800, 0x98420000, 0x0a119000 -> IF/ID shows pc 0, 4, 8 in turn with those words; pc_o=12 after the third edge.
- stall_i high for 2 cycles while pc_o=8 -> pc_o stays 8 and if_id_pc stays 4 for both cycles; fetch resumes at 8 when stall_i drops.
- redirect_valid with redirect_pc=0x22 and stall_i=1 in the same cycle -> pc_o=0x20, if_id_valid=0 on the next edge; the instruction at 0x20 is latched one edge later.
- Word 0xfc000000 at pc 0x14 -> IF/ID holds it with valid=1, halted=1, and pc_o stays 0x14. Next edge gives if_id_valid=0. A redirect to 0x0 then clears halted and fetch restarts at 0.
- pc_o reaches 260 (index 65) -> no latch, halted=1, if_id_valid=0.
- Assert reset mid-HALT with redirect_valid=1 -> pc_o=RESET_PC and all outputs equal the reset values; with FETCH_PERF_EN defined, all counters read 0.

Source files
------------

// File: rtl/fetch_sequencer_if.sv
// fetch_sequencer_if: fetch-stage bus between hazard/branch logic, instruction memory and IF/ID.
// FETCH_PERF_EN adds the performance-counter signals.
interface fetch_sequencer_if;
  logic        stall_i;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] instr_i;
  logic [31:0] pc_o;
  logic        if_id_valid;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc;
  logic        halted;
`ifdef FETCH_PERF_EN
  logic [31:0] fetch_count;
  logic [31:0] bubble_count;
  logic [15:0] redirect_count;
`endif
  modport master (
    input  stall_i, redirect_valid, redirect_pc, instr_i,
`ifdef FETCH_PERF_EN
    output fetch_count, bubble_count, redirect_count,
`endif
    output pc_o, if_id_valid, if_id_instr, if_id_pc, halted
  );
  modport slave (
    output stall_i, redirect_valid, redirect_pc, instr_i,
`ifdef FETCH_PERF_EN
    input  fetch_count, bubble_count, redirect_count,
`endif
    input  pc_o, if_id_valid, if_id_instr, if_id_pc, halted
  );
endinterface

// File: rtl/fetch_sequencer.sv
// fetch_sequencer: PC sequencing and IF/ID latch under stall, redirect and halt.
// FETCH_PERF_EN adds saturating fetch/bubble/redirect counters.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC    = 32'h0000_0000,
  parameter logic [5:0]  HALT_OPCODE = 6'b111111,
  parameter int          MEM_WORDS   = 65
) (
  input logic           clk,
  input logic           reset,
  fetch_sequencer_if.master bus
);
  localparam logic [0:0] RUN  = 1'b0;
  localparam logic [0:0] HALT = 1'b1;
  logic [0:0] state;
  logic       in_range;
  assign in_range = {2'b00, bus.pc_o[31:2]} < 32'(MEM_WORDS);
  assign bus.halted = state == HALT;
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= RUN;
      bus.pc_o <= RESET_PC;
      bus.if_id_valid <= 1'b0;
      bus.if_id_instr <= '0;
      bus.if_id_pc <= '0;
    end else if (bus.redirect_valid) begin
      state <= RUN;
      bus.pc_o <= {bus.redirect_pc[31:2], 2'b00};
      bus.if_id_valid <= 1'b0;
      bus.if_id_instr <= '0;
      bus.if_id_pc <= '0;
    end else if (state == HALT) begin
      if (!bus.stall_i) begin
        bus.if_id_valid <= 1'b0;
        bus.if_id_instr <= '0;
      end
    end else if (!bus.stall_i) begin
      bus.if_id_valid <= in_range;
      bus.if_id_instr <= in_range ? bus.instr_i : '0;
      if (in_range) bus.if_id_pc <= bus.pc_o;
      // a fetched halt stays at its own address so a resume-by-redirect is the only way on
      if (!in_range || bus.instr_i[31:26] == HALT_OPCODE) state <= HALT;
      else bus.pc_o <= bus.pc_o + 32'd4;
    end
  end
`ifdef FETCH_PERF_EN
  logic latch, bubble;
  assign latch  = !bus.redirect_valid && !bus.stall_i && state == RUN && in_range;
  assign bubble = bus.redirect_valid || (state == RUN && bus.stall_i);
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.fetch_count <= '0;
      bus.bubble_count <= '0;
      bus.redirect_count <= '0;
    end else begin
      if (latch && bus.fetch_count != '1) bus.fetch_count <= bus.fetch_count + 32'd1;
      if (bubble && bus.bubble_count != '1) bus.bubble_count <= bus.bubble_count + 32'd1;
      if (bus.redirect_valid && bus.redirect_count != '1) bus.redirect_count <= bus.redirect_count + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed plan plus randomized stimulus against a behavioural fetch model.
module tb_fetch_sequencer;
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;
  fetch_sequencer_if bus ();
  fetch_sequencer dut (.clk(clk), .reset(reset), .bus(bus));
  logic [31:0] mem [65];
  assign bus.instr_i = (bus.pc_o[31:2] < 30'd65) ? mem[bus.pc_o[8:2]] : 32'hFC00_0000;
  int passed = 0, total = 0;
  logic [31:0] m_pc, m_ins, m_ipc, m_fc, m_bc;
  logic [15:0] m_rc;
  logic m_v, m_h;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask
  task automatic model_step();
    logic [31:0] w;
    if (reset) begin
      m_pc = 0; m_v = 0; m_ins = 0; m_ipc = 0; m_h = 0; m_fc = 0; m_bc = 0; m_rc = 0;
    end else if (bus.redirect_valid) begin
      if (m_rc != 16'hFFFF) m_rc++;
      if (m_bc != 32'hFFFF_FFFF) m_bc++;
      m_pc = bus.redirect_pc & ~32'd3; m_v = 0; m_ins = 0; m_ipc = 0; m_h = 0;
    end else if (m_h) begin
      if (!bus.stall_i) begin m_v = 0; m_ins = 0; end
    end else if (bus.stall_i) begin
      if (m_bc != 32'hFFFF_FFFF) m_bc++;
    end else if (m_pc / 4 >= 65) begin
      m_v = 0; m_ins = 0; m_h = 1;
    end else begin
      w = mem[m_pc / 4];
      m_v = 1; m_ins = w; m_ipc = m_pc;
      if (m_fc != 32'hFFFF_FFFF) m_fc++;
      if (w[31:26] == 6'b111111) m_h = 1;
      else m_pc = m_pc + 4;
    end
  endtask
  task automatic compare_all();
    chk("pc_o", bus.pc_o, m_pc);
    chk("if_id_valid", 32'(bus.if_id_valid), 32'(m_v));
    chk("if_id_instr", bus.if_id_instr, m_ins);
    chk("if_id_pc", bus.if_id_pc, m_ipc);
    chk("halted", 32'(bus.halted), 32'(m_h));
`ifdef FETCH_PERF_EN
    chk("fetch_count", bus.fetch_count, m_fc);
    chk("bubble_count", bus.bubble_count, m_bc);
    chk("redirect_count", 32'(bus.redirect_count), 32'(m_rc));
`endif
  endtask
  task automatic cyc(input logic r, input logic rv, input logic [31:0] rpc, input logic st);
    reset = r; bus.redirect_valid = rv; bus.redirect_pc = rpc; bus.stall_i = st;
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask
  task automatic pin(input logic [31:0] pc, input logic v, input logic [31:0] ins, input logic [31:0] ipc, input logic h);
    chk("lit_pc_o", bus.pc_o, pc);
    chk("lit_valid", 32'(bus.if_id_valid), 32'(v));
    chk("lit_instr", bus.if_id_instr, ins);
    chk("lit_if_id_pc", bus.if_id_pc, ipc);
    chk("lit_halted", 32'(bus.halted), 32'(h));
  endtask
  initial begin
    logic [31:0] w;
    for (int i = 0; i < 65; i++) begin
      w = $urandom;
      if (w[31:26] == 6'b111111) w[31] = 1'b0;
      mem[i] = w;
    end
    mem[0] = 32'h0041_1800; mem[1] = 32'h9842_0000; mem[2] = 32'h0a11_9000; mem[5] = 32'hFC00_0000;
    reset = 1; bus.redirect_valid = 0; bus.redirect_pc = 0; bus.stall_i = 0;
    m_pc = 0; m_v = 0; m_ins = 0; m_ipc = 0; m_h = 0; m_fc = 0; m_bc = 0; m_rc = 0;
    cyc(1, 0, 0, 0);
    pin(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0); pin(4, 1, 32'h0041_1800, 0, 0);
    cyc(0, 0, 0, 0); pin(8, 1, 32'h9842_0000, 4, 0);
    cyc(0, 0, 0, 1); pin(8, 1, 32'h9842_0000, 4, 0);
    cyc(0, 0, 0, 1); pin(8, 1, 32'h9842_0000, 4, 0);
    cyc(0, 0, 0, 0); pin(12, 1, 32'h0a11_9000, 8, 0);
    cyc(0, 1, 32'h22, 1); pin(32'h20, 0, 0, 0, 0);
    cyc(0, 0, 0, 0); pin(32'h24, 1, mem[8], 32'h20, 0);
    cyc(0, 1, 32'h14, 0); pin(32'h14, 0, 0, 0, 0);
    cyc(0, 0, 0, 0); pin(32'h14, 1, 32'hFC00_0000, 32'h14, 1);
    cyc(0, 0, 0, 0); pin(32'h14, 0, 0, 32'h14, 1);
    cyc(0, 1, 0, 0); pin(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0); pin(4, 1, 32'h0041_1800, 0, 0);
    cyc(0, 1, 256, 0); pin(256, 0, 0, 0, 0);
    cyc(0, 0, 0, 0); pin(260, 1, mem[64], 256, 0);
    cyc(0, 0, 0, 0); pin(260, 0, 0, 256, 1);
    cyc(1, 1, 32'h40, 1); pin(0, 0, 0, 0, 0);
`ifdef FETCH_PERF_EN
    chk("lit_counters_zero", bus.fetch_count | bus.bubble_count | 32'(bus.redirect_count), 0);
`endif
    for (int i = 0; i < 10; i++) mem[$urandom_range(3, 64)][31:26] = 6'b111111;
    for (int i = 0; i < 800; i++) begin
      w = ($urandom_range(0, 19) == 0) ? 32'hFFFF_FFFC : 32'($urandom_range(0, 300));
      cyc($urandom_range(0, 63) == 0, $urandom_range(0, 11) == 0, w, $urandom_range(0, 3) == 0);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
